// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO frame receiver.
//   rx_state_t   : receive FSM states
//   parity_error : parity check for a received word and its parity bit
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // data_xor is the XOR-reduction of the data bits. For even parity (odd=0)
  // the total count of ones including the parity bit must be even. For odd
  // parity (odd=1) it must be odd. Returns 1 when the check fails.
  function automatic logic parity_error(input logic data_xor,
                                        input logic par_bit,
                                        input logic odd);
    return data_xor ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/sipo_rx_ctrl_if.sv
// Parallel word port of the SIPO frame receiver.
//   dout       : received word (holding buffer)
//   dout_valid : holding buffer full
//   dout_ready : consumer accepts dout when dout_valid & dout_ready
//   dout_perr  : parity error flag for the word on dout
//   dout_ferr  : framing error flag for the word on dout
// The master modport is used by the receiver. The slave modport is used by the consumer.
interface sipo_rx_ctrl_if #(parameter int WIDTH = 8) ();
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_perr;
  logic             dout_ferr;

  modport master (
    output dout, dout_valid, dout_perr, dout_ferr,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_valid, dout_perr, dout_ferr,
    output dout_ready
  );
endinterface

// File: rtl/sipo_shift_en.sv
// WIDTH-bit serial-in/parallel-out shift register with shift enable.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset, clears q
//   shift_en : when 1, din enters at the MSB and every bit moves one place toward bit0
//   din      : serial input
//   q        : parallel contents. After WIDTH shifts, the first bit shifted in is at bit0.
module sipo_shift_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi == WIDTH - 1) begin : g_msb
      assign q_next[gi] = shift_en ? din : q[gi];
    end else begin : g_lower
      assign q_next[gi] = shift_en ? q[gi+1] : q[gi];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Frame-level receive controller around a SIPO shift register.
// It detects the start bit and shifts WIDTH data bits, LSB first. It checks
// the optional parity bit and the stop bit. The word is then delivered
// through a one-word valid/ready holding buffer.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   rx_en    : 0 aborts any frame and holds the FSM in IDLE. It has priority over bit_tick.
//   bit_tick : one-cycle strobe. din is sampled only when it is 1.
//   din      : serial line, idles high
//   rx_bus   : parallel word port (dout, dout_valid, dout_ready, dout_perr, dout_ferr)
//   overrun  : one-cycle pulse when a completed word is dropped because the buffer is full
//   busy     : FSM not in IDLE
module sipo_rx_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 bit_tick,
  input  logic                 din,
  sipo_rx_ctrl_if.master       rx_bus,
  output logic                 overrun,
  output logic                 busy
);

  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic            ODD      = (PARITY_ODD != 0);

  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             perr_frame, perr_frame_next;
  logic [WIDTH-1:0] shift_data;
  logic             shift_en;
  logic             done;
  logic             ferr_new;

  logic [WIDTH-1:0] dout_reg;
  logic             valid_reg;
  logic             perr_reg;
  logic             ferr_reg;

  assign shift_en = (state == DATA) && bit_tick && rx_en;

  sipo_shift_en #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (din),
    .q        (shift_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      perr_frame <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      perr_frame <= perr_frame_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    perr_frame_next = perr_frame;
    done            = 1'b0;
    ferr_new        = 1'b0;
    if (!rx_en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (bit_tick) begin
      unique case (state)
        IDLE: begin
          if (!din) begin
            state_next      = DATA;
            cnt_next        = '0;
            // With parity disabled this stays 0 for the whole frame.
            perr_frame_next = 1'b0;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            // Clear here so the counter never goes past WIDTH-1.
            cnt_next   = '0;
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        PARITY: begin
          perr_frame_next = parity_error(^shift_data, din, ODD);
          state_next      = STOP;
        end
        STOP: begin
          // Stop tick: the frame is complete whatever the stop bit value.
          done       = 1'b1;
          ferr_new   = ~din;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Holding buffer. A completing frame loads the buffer if it is empty or is
  // being drained in this cycle. Otherwise the frame is dropped and overrun
  // pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid_reg || rx_bus.dout_ready) begin
          dout_reg  <= shift_data;
          perr_reg  <= perr_frame;
          ferr_reg  <= ferr_new;
          valid_reg <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_reg && rx_bus.dout_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx_bus.dout       = dout_reg;
  assign rx_bus.dout_valid = valid_reg;
  assign rx_bus.dout_perr  = perr_reg;
  assign rx_bus.dout_ferr  = ferr_reg;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
module tb_sipo_rx_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic rx_en;
  logic bit_tick;
  logic din;
  logic overrun;
  logic busy;

  sipo_rx_ctrl_if #(.WIDTH(8)) rx_bus ();

  sipo_rx_ctrl #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_en    (rx_en),
    .bit_tick (bit_tick),
    .din      (din),
    .rx_bus   (rx_bus),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic       perr;
    logic       ferr;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pop the next expected word and compare it with the holding buffer.
  task automatic check_word(input string name);
    exp_t e;
    check({name, "_valid"}, 32'(rx_bus.dout_valid), 32'd1);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_sb: scoreboard empty, got word %0h", name, rx_bus.dout);
    end else begin
      e = sb.pop_front();
      check({name, "_dout"}, 32'(rx_bus.dout), 32'(e.dout));
      check({name, "_perr"}, 32'(rx_bus.dout_perr), 32'(e.perr));
      check({name, "_ferr"}, 32'(rx_bus.dout_ferr), 32'(e.ferr));
      $display("word %s: dout=%02h perr=%0b ferr=%0b (exp %02h %0b %0b)",
               name, rx_bus.dout, rx_bus.dout_perr, rx_bus.dout_ferr, e.dout, e.perr, e.ferr);
    end
  endtask

  // One tick cycle. Returns on the falling edge right after the sampling edge.
  task automatic send_bit(input logic b, input logic with_ready);
    @(negedge clk);
    din      = b;
    bit_tick = 1'b1;
    if (with_ready) rx_bus.dout_ready = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
    if (with_ready) rx_bus.dout_ready = 1'b0;
  endtask

  // Full frame, with a tick every 4 clocks. Returns one clock after the stop tick.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic ready_on_stop, input logic check_pre);
    logic [10:0] bits;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && check_pre)
        check("valid_before_stop", 32'(rx_bus.dout_valid), 32'd0);
      send_bit(bits[i], (i == 10) && ready_on_stop);
      if (i != 10) repeat (3) @(negedge clk);
    end
    din = 1'b1;
  endtask

  task automatic accept(input string name);
    @(negedge clk);
    rx_bus.dout_ready = 1'b1;
    @(negedge clk);
    rx_bus.dout_ready = 1'b0;
    check({name, "_drained"}, 32'(rx_bus.dout_valid), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // data, parity bit, stop bit -> dout, perr, ferr (even parity)
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};

    reset = 1'b0;
    rx_en = 1'b1;
    bit_tick = 1'b0;
    din = 1'b1;
    rx_bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dout", 32'(rx_bus.dout), 32'd0);
    check("rst_valid", 32'(rx_bus.dout_valid), 32'd0);
    check("rst_perr", 32'(rx_bus.dout_perr), 32'd0);
    check("rst_ferr", 32'(rx_bus.dout_ferr), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames into an empty buffer
    for (int v = 0; v < 7; v++) begin
      sb.push_back('{vecs[v].exp_dout, vecs[v].exp_perr, vecs[v].exp_ferr});
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 1'b0, 1'b1);
      check_word($sformatf("vec%0d", v));
      check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'd0);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      accept($sformatf("vec%0d", v));
    end

    // Overrun: second frame while the buffer is full and not drained
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    check_word("ovr_first");
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_dout_kept", 32'(rx_bus.dout), 32'h3C);
    check("ovr_valid_kept", 32'(rx_bus.dout_valid), 32'd1);
    @(negedge clk);
    check("ovr_pulse_end", 32'(overrun), 32'd0);
    $display("overrun sequence: dout=%02h overrun_end=%0b", rx_bus.dout, overrun);
    accept("ovr");

    // Accept on the same clock as a completion: the new word replaces the old one
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    check_word("swap_first");
    sb.push_back('{8'hC3, 1'b0, 1'b0});
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
    check_word("swap_second");
    check("swap_overrun", 32'(overrun), 32'd0);
    accept("swap");

    // Abort with rx_en=0 after the 4th data tick
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(negedge clk);
      send_bit(1'b1, 1'b0);
    end
    check("abort_busy_before", 32'(busy), 32'd1);
    rx_en = 1'b0;
    @(negedge clk);
    check("abort_busy_after", 32'(busy), 32'd0);
    rx_en = 1'b1;
    din = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_valid", 32'(rx_bus.dout_valid), 32'd0);
    $display("abort sequence: busy=%0b valid=%0b", busy, rx_bus.dout_valid);
    sb.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
    check_word("after_abort");
    accept("after_abort");

    // Asynchronous reset mid-DATA while holding a word
    sb.push_back('{8'h5A, 1'b0, 1'b1});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    check_word("pre_reset");
    send_bit(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    send_bit(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    send_bit(1'b0, 1'b0);
    check("prerst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_dout", 32'(rx_bus.dout), 32'd0);
    check("arst_valid", 32'(rx_bus.dout_valid), 32'd0);
    check("arst_ferr", 32'(rx_bus.dout_ferr), 32'd0);
    check("arst_perr", 32'(rx_bus.dout_perr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    $display("async reset: dout=%02h valid=%0b busy=%0b", rx_bus.dout, rx_bus.dout_valid, busy);
    @(negedge clk);
    reset = 1'b1;

    // din low between ticks must not start a frame
    din = 1'b0;
    repeat (6) @(negedge clk);
    check("no_false_start", 32'(busy), 32'd0);
    din = 1'b1;
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
